cpu_pipe_elastic: RTL and testbench

- Parametrised successor to the fixed if/id/ex/mem/wb latches: a DEPTH-stage, WIDTH-bit pipeline register chain.
- Per-stage valid bits and valid/ready backpressure.
- Bubble collapsing: an empty stage always accepts from behind, even while downstream is stalled.
- Per-stage flush for branch/jump squash, plus a registered occupancy count.
- Sits between any two CPU stages, or spans several, in the next-generation pipelined core.

---
 rtl/cpu_pipe_pkg.sv | 21 ++
 rtl/cpu_pipe_slot.sv | 30 +++
 rtl/cpu_pipe_elastic.sv | 120 ++++++++++++
 tb/tb_cpu_pipe_elastic.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
package cpu_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Occupancy counts up to DEPTH stage beats plus one optional skid beat.
    function automatic int occ_width(input int depth);
        return clog2(depth + 2);
    endfunction

endpackage

// File: rtl/cpu_pipe_slot.sv
// One pipeline stage: valid/data flops with load, hold and squash.
module cpu_pipe_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            // Own content has moved downstream, so its flush no longer matters here.
            valid <= in_valid;
            if (in_valid) begin
                data <= in_data;
            end
        end else begin
            valid <= valid & ~flush;
        end
    end

endmodule

// File: rtl/cpu_pipe_elastic.sv
// DEPTH-stage elastic pipeline with bubble collapsing, per-stage flush and occupancy.
// Optional one-entry input skid register enabled by CPU_PIPE_SKID_EN.
module cpu_pipe_elastic
    import cpu_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic [DEPTH-1:0] flush_mask,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];

    logic             in_fire;
    logic             out_fire;
    logic             front_valid;
    logic [WIDTH-1:0] front_data;

    // A stage can accept when any stage at or beyond it is empty, or the sink drains.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
        assign rdy[i] = out_ready | ~(&v[DEPTH-1:i]);
    end

    assign ev        = v & ~flush_mask;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef CPU_PIPE_SKID_EN
    logic             skid_valid;
    logic             skid_valid_nxt;
    logic [WIDTH-1:0] skid_data;
    logic             in_ready_q;

    assign in_ready       = in_ready_q;
    assign front_valid    = skid_valid | in_fire;
    assign front_data     = skid_valid ? skid_data : in_data;
    assign skid_valid_nxt = skid_valid ? ~rdy[0] : (in_fire & ~rdy[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready_q <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            in_ready_q <= ~skid_valid_nxt;
            if (in_fire && !rdy[0]) begin
                skid_data <= in_data;
            end
        end
    end
`else
    assign in_ready    = rdy[0];
    assign front_valid = in_fire;
    assign front_data  = in_data;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = front_valid;
            assign src_data  = front_data;
        end else begin : g_body
            assign src_valid = ev[i-1];
            assign src_data  = d[i-1];
        end

        cpu_pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (rdy[i]),
            .flush    (flush_mask[i]),
            .in_valid (src_valid),
            .in_data  (src_data),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    logic [DEPTH-1:0] not_consumed;
    logic [DEPTH-1:0] killed;
    logic [CW-1:0]    occ_nxt;

    // A beat leaving on out_fire is counted as consumed even if flushed this cycle.
    always_comb begin
        not_consumed            = '1;
        not_consumed[DEPTH-1]   = ~out_fire;
        killed                  = v & flush_mask & not_consumed;
        occ_nxt                 = occupancy + CW'(in_fire) - CW'(out_fire)
                                  - CW'($countones(killed));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_pipe_elastic.sv
// Directed self-checking bench for cpu_pipe_elastic at WIDTH=32, DEPTH=4.
module tb_cpu_pipe_elastic;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk        = 1'b0;
    logic         rst        = 1'b0;
    logic         in_valid   = 1'b0;
    logic         out_ready  = 1'b0;
    logic [W-1:0] in_data    = '0;
    logic [D-1:0] flush_mask = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [2:0]   occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_pipe_elastic #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush_mask (flush_mask),
        .occupancy  (occupancy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy,
                         input logic [D-1:0] fm);
        in_valid   = iv;
        in_data    = id;
        out_ready  = ordy;
        flush_mask = fm;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           got;
        int           exp_occ;
        logic [W-1:0] seen [2];

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 0);
`ifdef CPU_PIPE_SKID_EN
        chk("rst_in_ready", in_ready, 0);
`else
        chk("rst_in_ready", in_ready, 1);
`endif
        #10 rst = 1'b1;

        // Free-flowing stream 1..8, first output in cycle 4
        for (int i = 0; i < 12; i++) begin
            drive(i < 8, W'(i + 1), 1'b1, '0);
            exp_occ = (i < 4) ? i : ((i <= 8) ? 4 : 12 - i);
            chk("stream_occ", occupancy, W'(exp_occ));
            chk("stream_out_valid", out_valid, W'(i >= 4));
            if (i >= 4) chk("stream_out_data", out_data, W'(i - 3));
            tick();
        end
        drive(1'b0, '0, 1'b1, '0);
        chk("stream_empty_occ", occupancy, 0);
        chk("stream_empty_valid", out_valid, 0);

        // Stall fill, held in_valid is not lost
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(i + 1), 1'b0, '0);
            chk("fill_in_ready", in_ready, 1);
            tick();
        end
        drive(1'b1, 32'h5, 1'b0, '0);
        chk("full_in_ready", in_ready, 0);
        chk("full_occ", occupancy, 4);
        chk("full_out_data", out_data, 1);
        tick();
        drive(1'b1, 32'h5, 1'b0, '0);
        chk("full_in_ready_hold", in_ready, 0);
        tick();
        drive(1'b1, 32'h5, 1'b1, '0);
        chk("release_in_ready", in_ready, 1);
        chk("release_out_data", out_data, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, '0);
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, W'(k + 2));
            tick();
        end
        drive(1'b0, '0, 1'b1, '0);
        chk("drain_done_valid", out_valid, 0);
        chk("drain_done_occ", occupancy, 0);

        // Bubble collapse: A and B pack against the stalled sink
        drive(1'b1, 32'hA, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        drive(1'b1, 32'hB, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        tick();
        chk("bubble_occ", occupancy, 2);
        chk("bubble_in_ready", in_ready, 1);
        chk("bubble_out_data", out_data, 32'hA);
        drive(1'b0, '0, 1'b1, '0);
        chk("bubble_first", out_data, 32'hA);
        tick();
        drive(1'b0, '0, 1'b1, '0);
        chk("bubble_second_valid", out_valid, 1);
        chk("bubble_second", out_data, 32'hB);
        tick();
        drive(1'b0, '0, 1'b1, '0);
        chk("bubble_done", out_valid, 0);

        // Flush middle stages of a full, stalled pipe
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(i + 1), 1'b0, '0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 4'b0110);
        chk("flush_pre_occ", occupancy, 4);
        chk("flush_in_ready", in_ready, 0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("flush_post_occ", occupancy, 2);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b1, '0);
            if (out_valid) begin
                if (got < 2) seen[got] = out_data;
                got++;
            end
            tick();
        end
        chk("flush_count", W'(got), 2);
        chk("flush_beat0", seen[0], 1);
        chk("flush_beat1", seen[1], 4);

        // Simultaneous in_fire, out_fire and flush of stage 0
        drive(1'b1, 32'h11, 1'b0, '0);
        tick();
        drive(1'b1, 32'h12, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        drive(1'b1, 32'h13, 1'b0, '0);
        tick();
        drive(1'b1, 32'h14, 1'b1, 4'b0001);
        chk("mix_pre_occ", occupancy, 3);
        chk("mix_in_ready", in_ready, 1);
        chk("mix_out_data", out_data, 32'h11);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("mix_post_occ", occupancy, 2);
        chk("mix_post_data", out_data, 32'h12);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b1, '0);
            if (out_valid) begin
                if (got < 2) seen[got] = out_data;
                got++;
            end
            tick();
        end
        chk("mix_count", W'(got), 2);
        chk("mix_beat0", seen[0], 32'h12);
        chk("mix_beat1", seen[1], 32'h14);

        // All-ones flush never kills the incoming beat
        drive(1'b1, 32'h31, 1'b0, 4'b1111);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("flush_all_occ", occupancy, 1);
        tick();
        tick();
        tick();
        chk("flush_all_out", out_data, 32'h31);
        drive(1'b0, '0, 1'b1, '0);
        tick();

        // Asynchronous reset with three beats held
        drive(1'b1, 32'h21, 1'b0, '0);
        tick();
        drive(1'b1, 32'h22, 1'b0, '0);
        tick();
        drive(1'b1, 32'h23, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("prerst_occ", occupancy, 3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_data", out_data, 0);
        #3 rst = 1'b1;
        tick();
        drive(1'b0, '0, 1'b0, '0);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_occ", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
